dm_port_arbiter: RTL
====================

// Module: dm_port_arbiter
// PURPOSE
//  Shares the single-ported data memory (DM) between the CPU MEM stage and a DMA/loader requester.
//  Sits between the EX/MEM register outputs and DM.
//  CPU has priority, with a starvation counter guaranteeing DMA a slot and a locked-burst mode for DMA.
//  Raises cpu_stall when the CPU loses the port; the stall freezes PC, IF/ID and the stage registers.
// PARAMETERS
//  ADDR_W        32  address width, CPU and DMA
//  DATA_W        32  data width
//  STARVE_LIMIT  4   consecutive CPU-won cycles with dma_valid high before DMA is forced a slot (>=1)
// PORTS
//  clk         in   1       clock, all state updates on posedge
//  rst         in   1       synchronous active-high reset
//  cpu_req     in   1       MEM stage holds a load/store this cycle
//  cpu_we      in   1       1=store, 0=load
//  cpu_addr    in   ADDR_W  MEM-stage ALU result
//  cpu_wdata   in   DATA_W  store data
//  cpu_rdata   out  DATA_W  load data, combinational from mem_rdata
//  cpu_stall   out  1       CPU denied port this cycle
//  dma_valid   in   1       DMA request valid
//  dma_we      in   1       1=write, 0=read
//  dma_lock    in   1       hold port after this beat (burst continues)
//  dma_addr    in   ADDR_W  DMA address
//  dma_wdata   in   DATA_W  DMA write data
//  dma_ready   out  1       DMA beat accepted this cycle (valid&ready = transfer)
//  dma_rdata   out  DATA_W  registered read data of last accepted read beat
//  dma_rvalid  out  1       one-cycle pulse, dma_rdata valid
//  mem_addr    out  ADDR_W  to DM MemAddr
//  mem_wdata   out  DATA_W  to DM MemWriteData
//  mem_we      out  1       to DM MemWrite
//  mem_rdata   in   DATA_W  from DM MemReadData (combinational read)
//  owner_dma   out  1       1 when DMA owns port this cycle (debug/status)
// BEHAVIOUR
//  - DM model: combinational read, write committed at posedge when mem_we=1.
//  - FSM states: ARB (per-cycle arbitration), HOLD (DMA burst owns port). Reset state ARB.
//  - ARB owner (combinational): DMA if dma_valid && (!cpu_req || starve_cnt==STARVE_LIMIT); else CPU.
//  - HOLD owner: always DMA; CPU never granted while in HOLD.
//  - dma_ready = owner_dma && dma_valid. cpu_stall = cpu_req && owner_dma.
//  - Port mux: owner_dma ? dma_{addr,wdata} : cpu_{addr,wdata};
//    mem_we = owner_dma ? (dma_valid&dma_we) : (cpu_req&cpu_we). When idle, mem_we=0.
//  - cpu_rdata = mem_rdata always; meaningful only when cpu_req && !cpu_stall.
//  - Transitions: ARB->HOLD on accepted DMA beat with dma_lock=1. HOLD->ARB on accepted beat with
//    dma_lock=0. HOLD with dma_valid=0: stay in HOLD, port idle, CPU stalled (no timeout).
//  - starve_cnt (width clog2(STARVE_LIMIT+1)): in ARB, +1 (saturating at STARVE_LIMIT) when
//    dma_valid && cpu_req && CPU won; cleared on any DMA grant or when dma_valid=0. Held in HOLD.
//  - Read return: on accepted beat with dma_we=0, dma_rdata<=mem_rdata, dma_rvalid<=1 next cycle;
//    otherwise dma_rvalid<=0, dma_rdata holds. Latency = 1 cycle.
//  - Simultaneous requests, both valid, starve_cnt<limit: CPU wins, DMA waits (dma_ready=0).
//  - Address/data are not range-checked; DM address wrap is the DM's concern.
//  - Reset (any cycle, including mid-burst): state=ARB, starve_cnt=0, dma_rvalid=0, dma_rdata=0.
//    While rst=1: mem_we=0, dma_ready=0, cpu_stall=0, owner_dma=0.
//    An in-flight burst is dropped; the DMA must re-issue.
// TESTING
//  1 CPU only: cpu_req=1, cpu_we=1, addr=0x10, wdata=0xA5 -> mem_we=1, cpu_stall=0, DM[0x10]=0xA5 next cycle.
//  2 DMA only read: dma_valid=1, we=0, addr=0x10 -> dma_ready=1 same cycle; next cycle dma_rvalid=1, dma_rdata=0xA5.
//  3 Starvation: cpu_req and dma_valid high continuously, STARVE_LIMIT=4 -> CPU wins 4 cycles;
//    cycle 5 owner_dma=1, cpu_stall=1; cycle 6 CPU wins again.
//  4 Burst: DMA writes 3 beats, dma_lock=1,1,0, with cpu_req=1 -> cpu_stall=1 for 3 cycles
//    (once DMA granted); ARB after beat 3; DM holds all three words.
//  5 HOLD gap: dma_lock beat then dma_valid=0 for 2 cycles -> mem_we=0, cpu_stall=1 both cycles, state HOLD.
//  6 Reset mid-burst: rst=1 in HOLD -> next cycle state ARB, dma_rvalid=0, starve_cnt=0;
//    mem_we=0 during rst; CPU granted first cycle after rst.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// rtl/dm_port_arbiter.sv - data memory port arbiter between CPU MEM stage and DMA requester
// CPU has priority; a starvation counter forces DMA slots and dma_lock holds the port for bursts.
module dm_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              dma_valid,
  input  logic              dma_we,
  input  logic              dma_lock,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  output logic              dma_ready,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              dma_rvalid,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              owner_dma
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  localparam logic [0:0] ST_ARB  = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] starve_cnt;
  logic             dma_win;

  always_comb begin
    dma_win = 1'b0;
    if (state == ST_HOLD) begin
      dma_win = 1'b1;
    end else begin
      dma_win = dma_valid && (!cpu_req || (starve_cnt == CNT_MAX));
    end
  end

  // Reset overrides ownership so nothing reaches DM while rst is high.
  assign owner_dma = !rst && dma_win;
  assign dma_ready = owner_dma && dma_valid;
  assign cpu_stall = cpu_req && owner_dma;

  assign mem_addr  = owner_dma ? dma_addr  : cpu_addr;
  assign mem_wdata = owner_dma ? dma_wdata : cpu_wdata;
  assign mem_we    = !rst && (owner_dma ? (dma_valid && dma_we) : (cpu_req && cpu_we));
  assign cpu_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ARB;
      starve_cnt <= '0;
      dma_rvalid <= 1'b0;
      dma_rdata  <= '0;
    end else begin
      case (state)
        ST_ARB:  if (dma_ready && dma_lock)  state <= ST_HOLD;
        ST_HOLD: if (dma_ready && !dma_lock) state <= ST_ARB;
        default: state <= ST_ARB;
      endcase

      if (state == ST_ARB) begin
        if (dma_ready || !dma_valid) begin
          starve_cnt <= '0;
        end else if (cpu_req && (starve_cnt != CNT_MAX)) begin
          starve_cnt <= starve_cnt + CNT_W'(1);
        end
      end

      if (dma_ready && !dma_we) begin
        dma_rdata  <= mem_rdata;
        dma_rvalid <= 1'b1;
      end else begin
        dma_rvalid <= 1'b0;
      end
    end
  end

endmodule
